// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: state encoding,
// coin strobe bit positions, coin values in 5c units and change coin codes.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    // Bit positions inside the one-hot coin strobe {25c,10c,5c}
    localparam int COIN_IDX_5  = 0;
    localparam int COIN_IDX_10 = 1;
    localparam int COIN_IDX_25 = 2;

    // Coin values in 5c units
    localparam logic [2:0] UNIT_5  = 3'd1;
    localparam logic [2:0] UNIT_10 = 3'd2;
    localparam logic [2:0] UNIT_25 = 3'd5;

    // change_coin encodings
    localparam logic [1:0] CC_5  = 2'd0;
    localparam logic [1:0] CC_10 = 2'd1;
    localparam logic [1:0] CC_25 = 2'd2;

    // Value of a one-hot coin strobe; anything that is not a single coin is worth 0
    function automatic logic [2:0] coin_units(input logic [2:0] strobe);
        logic [2:0] val;
        val = 3'd0;
        if (strobe == (3'b001 << COIN_IDX_5))
            val = UNIT_5;
        else if (strobe == (3'b001 << COIN_IDX_10))
            val = UNIT_10;
        else if (strobe == (3'b001 << COIN_IDX_25))
            val = UNIT_25;
        return val;
    endfunction

endpackage

// File: rtl/vend_fsm_param_if.sv
// Coin-acceptor / dispenser / hopper signal bundle of the vending controller.
// The master side drives coins, cancel and hopper ready; the slave is the controller.
interface vend_fsm_param_if #(
    parameter int CREDIT_W = 6
) ();
    logic [2:0]          coin_in;
    logic                cancel;
    logic                vend;
    logic                coin_reject;
    logic                change_valid;
    logic                change_ready;
    logic [1:0]          change_coin;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output coin_in, cancel, change_ready,
        input  vend, coin_reject, change_valid, change_coin, credit, busy
    );

    modport slave (
        input  coin_in, cancel, change_ready,
        output vend, coin_reject, change_valid, change_coin, credit, busy
    );
endinterface

// File: rtl/vend_change_sel.sv
// Greedy change picker: largest coin not exceeding the remaining credit.
module vend_change_sel
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] credit_i,
    output logic [1:0]          change_coin_o,
    output logic [2:0]          coin_val_o
);

    // Compare at 32 bits so narrow credit widths still see the 25c threshold correctly
    always_comb begin
        change_coin_o = CC_5;
        coin_val_o    = UNIT_5;
        if (32'(credit_i) >= 32'(UNIT_25)) begin
            change_coin_o = CC_25;
            coin_val_o    = UNIT_25;
        end else if (32'(credit_i) >= 32'(UNIT_10)) begin
            change_coin_o = CC_10;
            coin_val_o    = UNIT_10;
        end
    end

endmodule

// File: rtl/vend_fsm_param.sv
// Vending controller: coin qualification, credit accumulation, vend pulse and
// one-coin-per-beat change payout through the hopper handshake.
//
//  state    | meaning
//  IDLE     | no credit, waiting for a coin
//  COLLECT  | 0 < credit < PRICE, accepting coins or cancel
//  DISPENSE | single cycle with vend high, credit holds the change due
//  CHANGE   | paying credit back one coin per valid&&ready beat
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int PRICE    = 2,
    parameter int CREDIT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    vend_fsm_param_if.slave bus
);

    localparam int SUM_W = CREDIT_W + 1;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                vend_q, vend_d;
    logic                reject_q, reject_d;

    logic [2:0]          coin_val;
    logic                coin_any;
    logic                coin_accept;
    logic [SUM_W-1:0]    sum;
    logic                overflow;
    logic                reaches_price;
    logic [1:0]          sel_coin;
    logic [2:0]          sel_val;
    logic [CREDIT_W-1:0] credit_after_beat;
    logic                change_valid;

    vend_change_sel #(
        .CREDIT_W (CREDIT_W)
    ) u_change_sel (
        .credit_i      (credit_q),
        .change_coin_o (sel_coin),
        .coin_val_o    (sel_val)
    );

    // Qualify the incoming coin; the extra sum bit flags credit overflow
    always_comb begin
        coin_any      = |bus.coin_in;
        coin_val      = coin_units(bus.coin_in);
        sum           = {1'b0, credit_q} + SUM_W'(coin_val);
        overflow      = sum[CREDIT_W];
        reaches_price = sum >= SUM_W'(PRICE);
        coin_accept   = coin_any && $onehot(bus.coin_in) && !overflow && !bus.cancel
                        && ((state_q == IDLE) || (state_q == COLLECT));
        credit_after_beat = credit_q - CREDIT_W'(sel_val);
    end

    // Next state, credit and output pulses
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        vend_d   = 1'b0;
        reject_d = coin_any && !coin_accept;
        case (state_q)
            IDLE, COLLECT: begin
                if ((state_q == COLLECT) && bus.cancel) begin
                    state_d = CHANGE;
                end else if (coin_accept) begin
                    if (reaches_price) begin
                        // no overflow here, so the low bits hold the whole sum
                        state_d  = DISPENSE;
                        credit_d = sum[CREDIT_W-1:0] - CREDIT_W'(PRICE);
                        vend_d   = 1'b1;
                    end else begin
                        state_d  = COLLECT;
                        credit_d = sum[CREDIT_W-1:0];
                    end
                end
            end
            DISPENSE: begin
                state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                // greedy pick never exceeds credit, so the subtraction cannot wrap
                if (credit_q == '0) begin
                    state_d = IDLE;
                end else if (bus.change_ready) begin
                    credit_d = credit_after_beat;
                    if (credit_after_beat == '0)
                        state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // State, credit and registered pulse outputs; reset abandons any payout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
            vend_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            vend_q   <= vend_d;
            reject_q <= reject_d;
        end
    end

    assign change_valid     = (state_q == CHANGE);
    assign bus.change_valid = change_valid;
    assign bus.change_coin  = change_valid ? sel_coin : CC_5;
    assign bus.vend         = vend_q;
    assign bus.coin_reject  = reject_q;
    assign bus.credit       = credit_q;
    assign bus.busy         = (state_q == DISPENSE) || (state_q == CHANGE);

endmodule

// File: tb/tb_vend_fsm_param.sv
// Scoreboard bench for vend_fsm_param: three instances (PRICE/CREDIT_W = 2/6,
// 3/6, 7/3). Stimulus pushes expected vend/reject/change events; negedge
// monitors pop and compare whenever an instance presents one.
module tb_vend_fsm_param;

    localparam int K_VEND = 0;
    localparam int K_REJ  = 1;
    localparam int K_CHG  = 2;

    typedef struct {
        int kind;
        int coin;
        int credit;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vend_fsm_param_if #(.CREDIT_W(6)) ifa ();
    vend_fsm_param_if #(.CREDIT_W(6)) ifb ();
    vend_fsm_param_if #(.CREDIT_W(3)) ifc ();

    vend_fsm_param #(.PRICE(2), .CREDIT_W(6)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    vend_fsm_param #(.PRICE(3), .CREDIT_W(6)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    vend_fsm_param #(.PRICE(7), .CREDIT_W(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int checks = 0;
    int errors = 0;

    task automatic push(input int id, input int kind, input int coin, input int credit);
        exp_t e;
        e.kind = kind; e.coin = coin; e.credit = credit;
        case (id)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int id, input int kind, input int coin, input int credit);
        exp_t e;
        int found;
        found = 0;
        case (id)
            0: if (qa.size() > 0) begin e = qa.pop_front(); found = 1; end
            1: if (qb.size() > 0) begin e = qb.pop_front(); found = 1; end
            default: if (qc.size() > 0) begin e = qc.pop_front(); found = 1; end
        endcase
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL sb%0d unexpected event: got kind %0d coin %0d credit %0d, expected none",
                     id, kind, coin, credit);
        end else if (e.kind != kind || e.coin != coin || e.credit != credit) begin
            errors++;
            $display("FAIL sb%0d event: got kind %0d coin %0d credit %0d, expected kind %0d coin %0d credit %0d",
                     id, kind, coin, credit, e.kind, e.coin, e.credit);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.vend) sb_pop(0, K_VEND, 0, int'(ifa.credit));
            if (ifa.coin_reject) sb_pop(0, K_REJ, 0, int'(ifa.credit));
            if (ifa.change_valid && ifa.change_ready)
                sb_pop(0, K_CHG, int'(ifa.change_coin), int'(ifa.credit));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifb.vend) sb_pop(1, K_VEND, 0, int'(ifb.credit));
            if (ifb.coin_reject) sb_pop(1, K_REJ, 0, int'(ifb.credit));
            if (ifb.change_valid && ifb.change_ready)
                sb_pop(1, K_CHG, int'(ifb.change_coin), int'(ifb.credit));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.vend) sb_pop(2, K_VEND, 0, int'(ifc.credit));
            if (ifc.coin_reject) sb_pop(2, K_REJ, 0, int'(ifc.credit));
            if (ifc.change_valid && ifc.change_ready)
                sb_pop(2, K_CHG, int'(ifc.change_coin), int'(ifc.credit));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one coin strobe for exactly one sampling edge
    task automatic coin(input int id, input logic [2:0] c);
        case (id)
            0: ifa.coin_in = c;
            1: ifb.coin_in = c;
            default: ifc.coin_in = c;
        endcase
        cyc();
        ifa.coin_in = 3'b000;
        ifb.coin_in = 3'b000;
        ifc.coin_in = 3'b000;
    endtask

    function automatic logic busy_of(input int id);
        case (id)
            0: return ifa.busy;
            1: return ifb.busy;
            default: return ifc.busy;
        endcase
    endfunction

    task automatic wait_idle(input int id, input int budget, input string name);
        int n;
        n = 0;
        while (busy_of(id) && n < budget) begin
            cyc();
            n++;
        end
        check_val(name, int'(busy_of(id)), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.coin_in = 3'b000; ifa.cancel = 1'b0; ifa.change_ready = 1'b0;
        ifb.coin_in = 3'b000; ifb.cancel = 1'b0; ifb.change_ready = 1'b0;
        ifc.coin_in = 3'b000; ifc.cancel = 1'b0; ifc.change_ready = 1'b0;
        rst_n = 1'b0;
        cyc(); cyc();
        check_val("rst vend", int'(ifa.vend), 0);
        check_val("rst coin_reject", int'(ifa.coin_reject), 0);
        check_val("rst change_valid", int'(ifa.change_valid), 0);
        check_val("rst change_coin", int'(ifa.change_coin), 0);
        check_val("rst credit", int'(ifa.credit), 0);
        check_val("rst busy", int'(ifa.busy), 0);
        rst_n = 1'b1;
        cyc();

        // 1: 5c + 5c at PRICE=2 vends with no change
        coin(0, 3'b001);
        check_val("t1 credit after 5c", int'(ifa.credit), 1);
        push(0, K_VEND, 0, 0);
        coin(0, 3'b001);
        check_val("t1 vend after 2nd coin", int'(ifa.vend), 1);
        cyc(); cyc();
        check_val("t1 busy", int'(ifa.busy), 0);
        check_val("t1 credit", int'(ifa.credit), 0);
        check_val("t1 change_valid", int'(ifa.change_valid), 0);

        // 2: 25c at PRICE=2 -> change 10c then 5c back to back
        ifa.change_ready = 1'b1;
        push(0, K_VEND, 0, 3);
        push(0, K_CHG, 1, 3);
        push(0, K_CHG, 0, 1);
        coin(0, 3'b100);
        wait_idle(0, 20, "t2 idle");
        check_val("t2 credit", int'(ifa.credit), 0);

        // 3: 10c at PRICE=3 then cancel -> refund one 10c
        ifb.change_ready = 1'b1;
        coin(1, 3'b010);
        check_val("t3 credit", int'(ifb.credit), 2);
        check_val("t3 busy", int'(ifb.busy), 0);
        push(1, K_CHG, 1, 2);
        ifb.cancel = 1'b1;
        cyc();
        ifb.cancel = 1'b0;
        wait_idle(1, 20, "t3 idle");
        check_val("t3 credit end", int'(ifb.credit), 0);
        // coin together with cancel in IDLE: coin rejected, cancel ignored
        push(1, K_REJ, 0, 0);
        ifb.cancel = 1'b1;
        coin(1, 3'b001);
        ifb.cancel = 1'b0;
        cyc();
        check_val("t3 coin+cancel credit", int'(ifb.credit), 0);
        check_val("t3 coin+cancel busy", int'(ifb.busy), 0);

        // 4a: non-one-hot strobes are rejected and leave credit alone
        push(0, K_REJ, 0, 0);
        coin(0, 3'b011);
        push(0, K_REJ, 0, 0);
        coin(0, 3'b111);
        coin(0, 3'b001);
        push(0, K_REJ, 0, 1);
        coin(0, 3'b011);
        check_val("t4a credit kept", int'(ifa.credit), 1);
        push(0, K_VEND, 0, 0);
        coin(0, 3'b001);
        cyc(); cyc();

        // 4c: CREDIT_W=3, PRICE=7: overflow reject at credit 6, then 5c hits max and vends
        coin(2, 3'b100);
        coin(2, 3'b001);
        check_val("t4c credit 6", int'(ifc.credit), 6);
        push(2, K_REJ, 0, 6);
        coin(2, 3'b010);
        cyc();
        check_val("t4c credit after reject", int'(ifc.credit), 6);
        check_val("t4c busy after reject", int'(ifc.busy), 0);
        push(2, K_VEND, 0, 0);
        coin(2, 3'b001);
        cyc(); cyc();
        check_val("t4c credit end", int'(ifc.credit), 0);

        // 5 + 4b: hopper stalls; coin during CHANGE rejected; offer held steady
        ifa.change_ready = 1'b0;
        push(0, K_VEND, 0, 3);
        coin(0, 3'b100);
        cyc();
        push(0, K_REJ, 0, 3);
        coin(0, 3'b001);
        for (int i = 0; i < 5; i++) begin
            check_val("t5 change_valid held", int'(ifa.change_valid), 1);
            check_val("t5 change_coin stable", int'(ifa.change_coin), 1);
            check_val("t5 credit held", int'(ifa.credit), 3);
            cyc();
        end
        push(0, K_CHG, 1, 3);
        push(0, K_CHG, 0, 1);
        ifa.change_ready = 1'b1;
        wait_idle(0, 20, "t5 idle");
        check_val("t5 credit end", int'(ifa.credit), 0);

        // 6: reset mid-CHANGE clears everything at once
        ifa.change_ready = 1'b0;
        push(0, K_VEND, 0, 3);
        coin(0, 3'b100);
        cyc();
        check_val("t6 in change", int'(ifa.change_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6 rst vend", int'(ifa.vend), 0);
        check_val("t6 rst coin_reject", int'(ifa.coin_reject), 0);
        check_val("t6 rst change_valid", int'(ifa.change_valid), 0);
        check_val("t6 rst change_coin", int'(ifa.change_coin), 0);
        check_val("t6 rst credit", int'(ifa.credit), 0);
        check_val("t6 rst busy", int'(ifa.busy), 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        check_val("t6 idle busy", int'(ifa.busy), 0);
        check_val("t6 idle credit", int'(ifa.credit), 0);
        ifa.change_ready = 1'b1;
        push(0, K_VEND, 0, 0);
        coin(0, 3'b010);
        cyc(); cyc();
        check_val("t6 end busy", int'(ifa.busy), 0);
        check_val("t6 end credit", int'(ifa.credit), 0);

        cyc(); cyc(); cyc();
        check_val("sb0 pending", qa.size(), 0);
        check_val("sb1 pending", qb.size(), 0);
        check_val("sb2 pending", qc.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
